comp_4_2_row_pipe: RTL and testbench
====================================

// Module: comp_4_2_row_pipe
// PURPOSE
//  Parametrised row of W chained 4:2 compressors that reduces four W-bit partial-product rows plus a row carry-in
//  to a sum/carry pair, followed by an elastic LAT-stage pipeline with valid/ready flow control.
//  Next-generation reduction slice for the Dadda multiplier datapath; sits between partial-product generation
//  and the final adder, and allows pipelining and backpressure of the reduction tree.
// PARAMETERS
//  W    8  bits per operand row = number of chained 4:2 cells (W >= 2)
//  LAT  2  pipeline register stages after the compressor row (1..4); LAT outside range -> $error at elaboration
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in0..in3   in   W      operand rows, same bit weight (bit i = 2^i)
//  cin        in   1      row carry-in, weight 2^0, fed to cell 0 horizontal carry input
//  flush      in   1      synchronous: drop all in-flight beats
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum_o      out  W+1    {row cout, cell sums}; bit i weight 2^i
//  carry_o    out  W+1    {cell carries, 1'b0}; bit i weight 2^i
//  res_o      out  W+2    sum_o + carry_o (only with COMP42_CPA_EN; else tied 0)
// BEHAVIOUR
//  - Cell i: in0[i]+in1[i]+in2[i]+in3[i]+hc_in[i] = s[i] + 2*(c[i] + hc_out[i]).
//    hc_out[i] depends only on in0..in2[i], never on hc_in[i] (no ripple). hc_in[0] = cin; hc_in[i] = hc_out[i-1].
//  - Invariant: sum_o + carry_o == in0+in1+in2+in3+cin (exact, no wrap; max 4*(2^W-1)+1 < 2^(W+2)).
//  - Compressor row is combinational on the input side. Stage k holds {valid_k, sum, carry}.
//  - Stage k loads when valid_{k-1} && (!valid_k || advance_k), where advance_k means stage k+1 or the output
//    takes its beat. Last stage advances on out_valid && out_ready.
//  - in_ready = !valid_1 || advance_1 (combinational through stall chain, no bubble). Beat accepted on
//    in_valid && in_ready.
//  - Latency: exactly LAT cycles from acceptance to out_valid with no stall. Throughput: 1 beat/cycle.
//  - Stall: out_valid && !out_ready holds sum_o/carry_o/res_o stable; upstream stages fill in order and no beat
//    is lost or duplicated. Pipeline full (all LAT valid and out_ready=0) -> in_ready=0.
//  - Simultaneous accept and emit at full pipeline: allowed, in_ready=1 when out_ready=1.
//  - flush: all valid_k cleared next edge, an in-flight beat on the same cycle is discarded,
//    in_ready=1 in the flush cycle; data registers not cleared.
//  - Reset (async assert, any time incl. mid-stall): all valid_k=0, all data regs=0, out_valid=0,
//    sum_o=carry_o=res_o=0; in_ready=1 once rst_n=1.
//  - Output data with out_valid=0 is don't-care for checking, but is 0 after reset.
// CONFIGURATION
//  - COMP42_CPA_EN defined: carry-propagate adder after last stage registered as an extra stage;
//    latency LAT+1, res_o = sum_o + carry_o of the same beat, handshake rules unchanged.
//  - Not defined: no adder, latency LAT, res_o tied to 0.
// TESTING
//  1 W=8 LAT=2: in0..3=8'hFF, cin=1, out_ready=1 -> after 2 cycles sum_o+carry_o=1021, 
//    res_o=10'd1021 (CPA build, cycle 3).
//  2 Reset mid-flight: 2 beats accepted, rst_n=0 for 1 cycle -> out_valid=0, outputs 0, no stale beat emitted.
//  3 Backpressure: stream 6 beats (in0=k, others 0, cin=0), out_ready=0 for 5 cycles -> in_ready drops after
//    LAT beats; on release, beats emerge in order 0..5, sums exact, none lost.
//  4 Full-throughput: in_valid=out_ready=1 for 100 random beats -> one result/cycle, each matches golden sum.
//  5 flush with 2 beats in flight and in_valid=1 -> next cycle out_valid=0; next accepted beat is first out.
//  6 Random: 10k beats, random in_valid/out_ready, W in {4,8,16}, LAT in {1,4} -> scoreboard exact, cin toggled.

Source files
------------

// File: rtl/comp_4_2_row_pipe.sv
// -----------------------------------------------------------------------------
// comp_4_2_row_pipe
//
// Purpose:
//   This block is one reduction slice of the Dadda multiplier. It holds a row of
//   W chained 4:2 compressors. The row takes four W-bit partial-product rows
//   plus a row carry-in and reduces them to a redundant sum/carry pair. An
//   elastic pipeline with valid/ready flow control follows the row, so the
//   reduction tree can be pipelined and can absorb backpressure.
//
// Configuration:
//   COMP42_CPA_EN  When defined, a carry-propagate adder (sum_o + carry_o) is
//                  added after the last stage as one extra registered stage.
//                  Latency becomes LAT+1 and res_o carries the resolved sum.
//                  When undefined, there is no adder, latency is LAT and res_o
//                  is tied to 0.
//
// Parameters:
//   W    bits per operand row, which is also the number of 4:2 cells (W >= 2)
//   LAT  pipeline register stages after the compressor row (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   in0..in3   operand rows, all of the same weight (bit i = 2^i)
//   cin        row carry-in, weight 2^0
//   flush      synchronous drop of every in-flight beat
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum_o      {row carry-out, cell sums}
//   carry_o    {cell carries, 1'b0}
//   res_o      sum_o + carry_o (CPA build only, otherwise 0)
// -----------------------------------------------------------------------------
module comp_4_2_row_pipe #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic         cin,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   sum_o,
    output logic [W:0]   carry_o,
    output logic [W+1:0] res_o
);

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("comp_4_2_row_pipe: LAT must be in 1..4");
    end
    if (W < 2) begin : g_bad_w
        $error("comp_4_2_row_pipe: W must be at least 2");
    end

`ifdef COMP42_CPA_EN
    localparam int NS = LAT + 1;
`else
    localparam int NS = LAT;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ------------------------------------------------------------------
    // Compressor row (combinational)
    // Each cell is built from two full adders. The first full adder adds
    // in0..in2, and its carry is the horizontal carry-out. That carry never
    // depends on hc[i], so carries cannot ripple along the row. The second
    // full adder folds in in3 and the horizontal carry-in.
    // ------------------------------------------------------------------
    logic [W:0]   hc;
    logic [W-1:0] s1;
    logic [W-1:0] row_s;
    logic [W-1:0] row_c;
    logic [W:0]   row_sum;
    logic [W:0]   row_carry;

    always_comb begin
        hc    = '0;
        s1    = '0;
        row_s = '0;
        row_c = '0;
        hc[0] = cin;
        for (int i = 0; i < W; i++) begin
            s1[i]    = in0[i] ^ in1[i] ^ in2[i];
            hc[i+1]  = maj3(in0[i], in1[i], in2[i]);
            row_s[i] = s1[i] ^ in3[i] ^ hc[i];
            row_c[i] = maj3(s1[i], in3[i], hc[i]);
        end
        row_sum   = {hc[W], row_s};
        row_carry = {row_c, 1'b0};
    end

    // ------------------------------------------------------------------
    // Elastic pipeline control
    // adv[k] is true when whatever stage k holds can move on this cycle.
    // That happens when the next stage is empty or is itself advancing. For
    // the last stage it is simply out_ready. Because adv is combinational
    // along the chain, a full pipeline with out_ready=1 still accepts a new
    // beat in the same cycle, so no bubble is created.
    // ------------------------------------------------------------------
    logic [NS:1] vld_q;
    logic [NS:1] vld_d;
    logic [NS:1] adv;
    logic [NS:1] load;

    always_comb begin
        adv     = '0;
        load    = '0;
        vld_d   = vld_q;
        adv[NS] = out_ready;
        for (int k = NS - 1; k >= 1; k--) begin
            adv[k] = !vld_q[k+1] || adv[k+1];
        end
        in_ready = flush || !vld_q[1] || adv[1];
        load[1]  = in_valid && !flush && (!vld_q[1] || adv[1]);
        for (int k = 2; k <= NS; k++) begin
            load[k] = vld_q[k-1] && !flush && (!vld_q[k] || adv[k]);
        end
        for (int k = 1; k <= NS; k++) begin
            if (flush) begin
                vld_d[k] = 1'b0;
            end else if (load[k]) begin
                vld_d[k] = 1'b1;
            end else if (adv[k]) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline data (a stage loads only on a handshake, otherwise it holds)
    // ------------------------------------------------------------------
    logic [W:0] sum_q   [1:NS];
    logic [W:0] sum_d   [1:NS];
    logic [W:0] carry_q [1:NS];
    logic [W:0] carry_d [1:NS];

    always_comb begin
        for (int k = 1; k <= NS; k++) begin
            sum_d[k]   = sum_q[k];
            carry_d[k] = carry_q[k];
        end
        if (load[1]) begin
            sum_d[1]   = row_sum;
            carry_d[1] = row_carry;
        end
        for (int k = 2; k <= NS; k++) begin
            if (load[k]) begin
                sum_d[k]   = sum_q[k-1];
                carry_d[k] = carry_q[k-1];
            end
        end
    end

`ifdef COMP42_CPA_EN
    // ------------------------------------------------------------------
    // Carry-propagate stage: it resolves the beat while that beat moves into
    // the output stage, so res_q always matches sum_q/carry_q of that stage.
    // ------------------------------------------------------------------
    logic [W+1:0] res_q;
    logic [W+1:0] res_d;

    always_comb begin
        res_d = res_q;
        if (load[NS]) begin
            res_d = {1'b0, sum_q[NS-1]} + {1'b0, carry_q[NS-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;
`else
    assign res_o = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= NS; k++) begin
                sum_q[k]   <= '0;
                carry_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 1; k <= NS; k++) begin
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
            end
        end
    end

    assign out_valid = vld_q[NS];
    assign sum_o     = sum_q[NS];
    assign carry_o   = carry_q[NS];

endmodule

// File: tb/tb_comp_4_2_row_pipe.sv
// -----------------------------------------------------------------------------
// tb_comp_4_2_row_pipe
// Scoreboard bench for comp_4_2_row_pipe (W=8, LAT=2).
// The driver pushes the golden total of every accepted beat. The monitor pops
// a total on every output handshake and checks sum_o + carry_o (and res_o).
// -----------------------------------------------------------------------------
module tb_comp_4_2_row_pipe;
    localparam int W   = 8;
    localparam int LAT = 2;
`ifdef COMP42_CPA_EN
    localparam int LE = LAT + 1;
`else
    localparam int LE = LAT;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0, in1, in2, in3;
    logic         cin;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum_o;
    logic [W:0]   carry_o;
    logic [W+1:0] res_o;

    comp_4_2_row_pipe #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .carry_o   (carry_o),
        .res_o     (res_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: it pops on each output handshake and checks that held outputs
    // stay stable while stalled.
    bit           stall_pending = 1'b0;
    logic [W:0]   prev_sum, prev_carry;
    logic [W+1:0] prev_res;
    int           mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
                chk("stall_sum_held", 32'(sum_o), 32'(prev_sum));
                chk("stall_carry_held", 32'(carry_o), 32'(prev_carry));
                chk("stall_res_held", 32'(res_o), 32'(prev_res));
                stall_pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_total", 32'(int'(sum_o) + int'(carry_o)), 32'(mon_e));
`ifdef COMP42_CPA_EN
                    chk("beat_res", 32'(res_o), 32'(mon_e));
`else
                    chk("res_tied0", 32'(res_o), 32'd0);
`endif
                end
            end else if (out_valid && !flush) begin
                stall_pending = 1'b1;
                prev_sum      = sum_o;
                prev_carry    = carry_o;
                prev_res      = res_o;
            end
        end
    end

    // This task runs one cycle. Inputs are already driven at posedge+1. The
    // accept decision is sampled at the negedge, and the task returns at the
    // next posedge+1.
    task automatic cyc(output bit acc);
        acc = 1'b0;
        @(negedge clk);
        if (rst_n && !flush && in_valid && in_ready) begin
            exp_q.push_back(int'(in0) + int'(in1) + int'(in2) + int'(in3) + int'(cin));
            acc = 1'b1;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int b;
        b         = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && b < 300) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk(nm, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit acc;
    int k, accn, n0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; cin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", 32'(sum_o), 32'd0);
        chk("rst_carry", 32'(carry_o), 32'd0);
        chk("rst_res", 32'(res_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Test 1: all-ones rows with cin=1 give 1021, split as 0x1FF + 0x1FE
        in0 = 8'hFF; in1 = 8'hFF; in2 = 8'hFF; in3 = 8'hFF; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc(acc);
        chk("t1_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        for (int c = 1; c <= LE; c++) begin
            @(negedge clk);
            chk("t1_latency_valid", {31'd0, out_valid}, (c == LE) ? 32'd1 : 32'd0);
            if (c == LE) begin
                chk("t1_sum_o", 32'(sum_o), 32'h1FF);
                chk("t1_carry_o", 32'(carry_o), 32'h1FE);
            end
            @(posedge clk);
            #1;
        end
        drain("t1_drain");

        // Test 2: reset while two beats are in flight
        out_ready = 1'b0; in_valid = 1'b1;
        in0 = 8'd3; in1 = 8'd0; in2 = 8'd0; in3 = 8'd0; cin = 1'b0;
        cyc(acc);
        in0 = 8'd4;
        cyc(acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        chk("t2_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t2_rst_sum", 32'(sum_o), 32'd0);
        chk("t2_rst_carry", 32'(carry_o), 32'd0);
        chk("t2_rst_res", 32'(res_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) cyc(acc);
        chk("t2_no_stale_beat", 32'(n_out - n0), 32'd0);

        // Test 3: backpressure, 6 beats in0=k, output stalled for 5 cycles
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            in_valid = 1'b1; in0 = 8'(k); in1 = '0; in2 = '0; in3 = '0; cin = 1'b0;
            out_ready = (c >= 5);
            cyc(acc);
            if (acc) k++;
            if (c == 4) chk("t3_fill_count", 32'(k), 32'(LE));
        end
        chk("t3_all_accepted", 32'(k), 32'd6);
        drain("t3_drain");

        // Test 4: full throughput, 100 beats
        accn = 0; n0 = n_out; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
            cin = i[0]; in_valid = 1'b1;
            cyc(acc);
            accn += int'(acc);
        end
        chk("t4_accepted", 32'(accn), 32'd100);
        chk("t4_outputs_inflight", 32'(n_out - n0), 32'(100 - LE));
        drain("t4_drain");

        // Test 5: flush with two beats in flight and in_valid=1
        out_ready = 1'b0; in_valid = 1'b1;
        in0 = 8'd10; in1 = 8'd20; in2 = '0; in3 = '0; cin = 1'b0;
        cyc(acc);
        in0 = 8'd11;
        cyc(acc);
        in0 = 8'd99; flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        n0 = n_out;
        in0 = 8'd55; in1 = '0; in2 = '0; in3 = '0; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc(acc);
        in_valid = 1'b0;
        drain("t5_drain");
        chk("t5_single_out", 32'(n_out - n0), 32'd1);

        // Test 6: random valid/ready, cin toggled
        accn = 0; n0 = n_out;
        for (int i = 0; i < 1500; i++) begin
            in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
            cin       = i[0];
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cyc(acc);
            accn += int'(acc);
        end
        drain("t6_drain");
        chk("t6_count", 32'(n_out - n0), 32'(accn));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
